sync_memory: RTL
================

# sync_memory

Parametrised synchronous single-port word memory for the simpleArchitecture datapath. It replaces the combinational, level-triggered store with a clocked array and a valid/ready request port. Reads have a fixed, configurable latency. A post-reset clear sequencer zeroes the array and then loads a constant into the top word. The CPU fetch/load-store logic talks to it directly.

## Interface

**Parameters**
- `DATA_W`, 16: word width in bits.
- `ADDR_W`, 16: address width; depth = 2^`ADDR_W` words.
- `RD_LAT`, 1: read latency in cycles; legal range 1..4; any other value is an elaboration error.
- `TOP_INIT`, 16'h00FF: value loaded into word 2^`ADDR_W`-1 by the init sequence; width `DATA_W`.

**Ports**
- `clk`, in, 1: the only clock; everything is rising-edge.
- `rst_n`, in, 1: asynchronous active-low reset.
- `req_valid`, in, 1: request present.
- `req_ready`, out, 1: block accepts a request this cycle.
- `req_write`, in, 1: 1 = write, 0 = read.
- `req_addr`, in, `ADDR_W`: word address.
- `req_wdata`, in, `DATA_W`: write data.
- `rsp_valid`, out, 1: read data valid, one-cycle pulse per read.
- `rsp_rdata`, out, `DATA_W`: read data; forced to 0 when `rsp_valid`=0.
- `busy`, out, 1: init sequence in progress.

## Operation

**States**
- `INIT`: entered on reset.
  - A clear counter walks address 0 .. 2^`ADDR_W`-2, writing 0 at one word per cycle.
  - Address 2^`ADDR_W`-1 is written with `TOP_INIT`.
  - Then go to `READY`.
- `READY`: `req_ready`=1; stays here until reset.

**Accepting requests**
- A request is accepted on a rising edge where `req_valid`&&`req_ready`. At most one request per cycle.
- Write:
  - The array is updated at the accept edge.
  - No response is generated; `rsp_valid` stays 0.
- Read:
  - The array is sampled at the accept edge, then carried through an `RD_LAT`-1 stage valid/data pipeline.
- Requests presented while `req_ready`=0 are ignored, not queued. The master must hold them.

**Ordering and hazards**
- A read of address A accepted on the cycle after a write to A returns the new data. Write-then-read ordering is strict.
- Responses return in request order.
- There is no response backpressure: the consumer must take `rsp_valid` when it arrives.
- Back-to-back reads give one `rsp_valid` per cycle.

**Width rules**
- Address is used unmodified; there is no wrap or masking beyond `ADDR_W`.
- `rsp_rdata` is exactly `DATA_W` wide, with no sign extension.

## Timing

**Reset values** (asynchronous, while `rst_n`=0)
- `req_ready`=0, `rsp_valid`=0, `rsp_rdata`=0, `busy`=1.
- Pipeline valid bits cleared; clear counter = 0.
- Array contents are not reset by `rst_n`.

**Init sequence**
- Edge k (k=1 after `rst_n` rises) writes address k-1.
- The edge that writes the top word also sets `req_ready`=1 and `busy`=0.
- Total 2^`ADDR_W` cycles.

**Read latency**
- Accept at edge N gives `rsp_valid`=1 and `rsp_rdata`=data in the cycle following edge N+`RD_LAT`-1.
- `RD_LAT`=1 means the data is visible right after the accept edge.

**Reset mid-operation**
- In-flight reads are dropped and `rsp_valid` goes 0 immediately.
- The init sequence restarts from address 0.

## Configuration

- Macro: `SYNC_MEMORY_CLEAR_EN`.
- Defined:
  - The full `INIT` sweep runs as above.
  - Every word reads 0 except the top word, which reads `TOP_INIT`.
- Undefined:
  - `INIT` lasts one cycle: edge 1 writes `TOP_INIT` to the top word only.
  - `req_ready`=1 and `busy`=0 after edge 1.
  - All other words are undefined (X in simulation) until written.

## Test plan

Unless stated otherwise, run with `ADDR_W`=4, `DATA_W`=16.

1. Init with macro on: release reset and count cycles.
   - `busy` falls exactly 16 edges after release.
   - Reads of 0..14 return 0x0000; read of 15 returns 0x00FF.
2. Write then read, `RD_LAT`=1:
   - Write 0xBEEF to 3, then read 3 on the next cycle.
   - `rsp_valid` appears 1 cycle after the read accept with 0xBEEF.
   - No `rsp_valid` is produced for the write.
3. `RD_LAT`=3 streaming:
   - 4 back-to-back reads of addresses 0..3, preloaded with 0x1111, 0x2222, 0x3333, 0x4444.
   - Four consecutive `rsp_valid` cycles, in order, starting 3 cycles after the first accept.
   - `rsp_rdata`=0 outside those cycles.
4. Request during init: `req_valid`=1 with a write of 0xAAAA to 5 while `busy`=1.
   - The request is ignored; after init, address 5 reads 0x0000.
5. Reset mid-read, `RD_LAT`=4:
   - Accept a read, then assert `rst_n`=0 two cycles later.
   - `rsp_valid` stays 0 and `busy`=1 immediately.
   - The init sequence restarts, with `busy` high for a further 16 edges after release.
6. Macro off:
   - `req_ready`=1 after edge 1.
   - Address 15 reads 0x00FF.
   - Address 4 reads X until written, then reads the written value.

Source files
------------

// File: rtl/sync_memory.sv
`default_nettype none
// ============================================================================
// Module      : sync_memory
// Description : Synchronous single-port word memory with a valid/ready
//               request port. Reads have a fixed latency of RD_LAT cycles.
//               After reset an init sequencer writes TOP_INIT into the top
//               word. It first zeroes the rest of the array when
//               SYNC_MEMORY_CLEAR_EN is defined.
//
// Configuration macro:
//   SYNC_MEMORY_CLEAR_EN  defined   : INIT writes 0 to words 0 .. 2^ADDR_W-2,
//                                     one word per cycle, then writes
//                                     TOP_INIT to the top word.
//                         undefined : INIT lasts one cycle and writes the top
//                                     word only. Other words stay undefined
//                                     until they are written.
//
// Parameters:
//   DATA_W   : word width in bits
//   ADDR_W   : address width; depth is 2^ADDR_W words
//   RD_LAT   : read latency in cycles; legal range is 1..4
//   TOP_INIT : value loaded into word 2^ADDR_W-1 by the init sequence
//
// Ports:
//   clk        in   clock; every register updates on the rising edge
//   rst_n      in   asynchronous active-low reset
//   req_valid  in   request present
//   req_ready  out  a request is accepted this cycle (READY state)
//   req_write  in   1 = write, 0 = read
//   req_addr   in   word address [ADDR_W]
//   req_wdata  in   write data [DATA_W]
//   rsp_valid  out  read data valid; one-cycle pulse per read
//   rsp_rdata  out  read data [DATA_W]; 0 whenever rsp_valid is 0
//   busy       out  init sequence in progress
//
// Revision    : 1.0 - initial release
// ============================================================================
module sync_memory #(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 16,
    parameter int                RD_LAT   = 1,
    parameter logic [DATA_W-1:0] TOP_INIT = 16'h00FF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy
);

    localparam int                c_depth    = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] c_top_addr = '1;

    // Reject an illegal read latency at elaboration time.
    generate
        if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
            $error("sync_memory: RD_LAT must be in the range 1..4");
        end
    endgenerate

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t            r_state;
    logic              r_ready;
    logic              r_busy;
    logic [DATA_W-1:0] r_mem [c_depth];
    logic              r_pv  [RD_LAT];
    logic [DATA_W-1:0] r_pd  [RD_LAT];

    logic              w_accept;
    logic              w_rd;
    logic              w_init_we;
    logic              w_init_last;
    logic [ADDR_W-1:0] w_init_addr;
    logic [DATA_W-1:0] w_init_data;
    logic              w_we;
    logic [ADDR_W-1:0] w_waddr;
    logic [DATA_W-1:0] w_wdata;

    assign w_accept = req_valid && r_ready;
    assign w_rd     = w_accept && !req_write;

    // The sequencer only writes once reset has been released. While rst_n is
    // held low the array is left untouched.
    assign w_init_we = (r_state == ST_INIT) && rst_n;

`ifdef SYNC_MEMORY_CLEAR_EN
    logic [ADDR_W-1:0] r_clr_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clr_addr <= '0;
        end else if (r_state == ST_INIT && r_clr_addr != c_top_addr) begin
            r_clr_addr <= r_clr_addr + 1'b1;
        end
    end

    assign w_init_addr = r_clr_addr;
    assign w_init_data = (r_clr_addr == c_top_addr) ? TOP_INIT : '0;
    assign w_init_last = (r_clr_addr == c_top_addr);
`else
    assign w_init_addr = c_top_addr;
    assign w_init_data = TOP_INIT;
    assign w_init_last = 1'b1;
`endif

    // Single write port. The sequencer and the request port never write in
    // the same cycle, because req_ready is low throughout INIT.
    assign w_we    = w_init_we || (w_accept && req_write);
    assign w_waddr = w_init_we ? w_init_addr : req_addr;
    assign w_wdata = w_init_we ? w_init_data : req_wdata;

    // The array has no reset. Its contents survive rst_n.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    // Init sequencer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_INIT;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
        end else begin
            case (r_state)
                ST_INIT: begin
                    if (w_init_last) begin
                        r_state <= ST_READY;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_READY;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Read pipeline. Stage 0 samples the array at the accept edge, so a write
    // accepted one edge earlier is already visible. Invalid stages carry zero
    // data, so the last stage can drive rsp_rdata directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LAT; i++) begin
                r_pv[i] <= 1'b0;
                r_pd[i] <= '0;
            end
        end else begin
            r_pv[0] <= w_rd;
            r_pd[0] <= w_rd ? r_mem[req_addr] : '0;
            for (int i = 1; i < RD_LAT; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_pd[i] <= r_pd[i-1];
            end
        end
    end

    assign req_ready = r_ready;
    assign busy      = r_busy;
    assign rsp_valid = r_pv[RD_LAT-1];
    assign rsp_rdata = r_pd[RD_LAT-1];

endmodule
`default_nettype wire
